// File: rtl/pong_pkg.sv
// Shared types and constants for the pong game-flow controller.
// Holds the game state encoding, text overlay codes and the BCD increment helper.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_NEWGAME = 2'd0,
        ST_PLAY    = 2'd1,
        ST_NEWBALL = 2'd2,
        ST_OVER    = 2'd3
    } state_e;

    localparam logic [1:0] TXT_LOGO    = 2'd0;
    localparam logic [1:0] TXT_PLAY    = 2'd1;
    localparam logic [1:0] TXT_NEWBALL = 2'd2;
    localparam logic [1:0] TXT_OVER    = 2'd3;

    localparam int V_TICK_LINE_DEF = 481;
    localparam int TIMER_TICKS_DEF = 120;

    // Two-digit BCD increment; 99 wraps to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = v[7:4];
        units = v[3:0];
        if (units >= 4'd9) begin
            units = 4'd0;
            if (tens >= 4'd9) begin
                tens = 4'd0;
            end else begin
                tens = tens + 4'd1;
            end
        end else begin
            units = units + 4'd1;
        end
        return {tens, units};
    endfunction

    function automatic logic [1:0] text_for_state(input state_e s);
        logic [1:0] t;
        case (s)
            ST_NEWGAME: t = TXT_LOGO;
            ST_PLAY:    t = TXT_PLAY;
            ST_NEWBALL: t = TXT_NEWBALL;
            ST_OVER:    t = TXT_OVER;
            default:    t = TXT_LOGO;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/pong_bcd_counter.sv
// Two-digit BCD counter with synchronous clear and increment, wrapping at 99.
module pong_bcd_counter
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] bcd
);

    logic [7:0] bcd_q;
    logic [7:0] bcd_d;

    // Next count: clear has priority over increment.
    always_comb begin
        bcd_d = bcd_q;
        if (clr) begin
            bcd_d = 8'h00;
        end else if (inc) begin
            bcd_d = bcd_inc(bcd_q);
        end else begin
            bcd_d = bcd_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd_q <= 8'h00;
        end else begin
            bcd_q <= bcd_d;
        end
    end

    assign bcd = bcd_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-flow sequencer: frame tick, game FSM, score, balls left and overlay mode.
// Optional high-score register enabled by defining PONG_CTRL_HISCORE_EN.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int V_TICK_LINE = V_TICK_LINE_DEF,
    parameter int TIMER_TICKS = TIMER_TICKS_DEF,
    parameter int TIMER_W     = 7,
    parameter int NUM_BALLS   = 3
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       p_tick,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       up,
    input  logic       down,
    input  logic       hit,
    input  logic       miss,
    output logic       refresh_tick,
    output logic       graph_still,
    output logic       ball_reset,
    output logic [7:0] score_bcd,
    output logic [1:0] balls_left,
`ifdef PONG_CTRL_HISCORE_EN
    output logic [7:0] hiscore_bcd,
`endif
    output logic [1:0] text_mode
);

    state_e               state_q, state_d;
    logic                 refresh_tick_q, refresh_tick_d;
    logic                 graph_still_q, graph_still_d;
    logic                 ball_reset_q, ball_reset_d;
    logic [1:0]           balls_left_q, balls_left_d;
    logic [1:0]           text_mode_q, text_mode_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 btn_s;
    logic                 timer_done_s;
    logic                 score_clr_s;
    logic                 score_inc_s;
`ifdef PONG_CTRL_HISCORE_EN
    logic [7:0]           hiscore_q, hiscore_d;
`endif

    assign btn_s        = up | down;
    assign timer_done_s = (timer_q == '0);

    // Next-state, timer, ball and score control for the game flow.
    always_comb begin
        state_d        = state_q;
        balls_left_d   = balls_left_q;
        timer_d        = timer_q;
        ball_reset_d   = 1'b0;
        score_clr_s    = 1'b0;
        score_inc_s    = 1'b0;
        refresh_tick_d = p_tick && (x == 10'd0) && (y == 10'(V_TICK_LINE));

        if (refresh_tick_q && !timer_done_s) begin
            timer_d = timer_q - TIMER_W'(1);
        end else begin
            timer_d = timer_q;
        end

        case (state_q)
            ST_NEWGAME: begin
                if (btn_s) begin
                    state_d      = ST_PLAY;
                    score_clr_s  = 1'b1;
                    balls_left_d = 2'(NUM_BALLS);
                    ball_reset_d = 1'b1;
                end else begin
                    state_d = ST_NEWGAME;
                end
            end
            ST_PLAY: begin
                if (miss) begin
                    // A miss right after a fresh serve still counts, but the pulse is not repeated.
                    ball_reset_d = ~ball_reset_q;
                    timer_d      = TIMER_W'(TIMER_TICKS);
                    if (balls_left_q == 2'd1) begin
                        balls_left_d = 2'd0;
                        state_d      = ST_OVER;
                    end else begin
                        balls_left_d = balls_left_q - 2'd1;
                        state_d      = ST_NEWBALL;
                    end
                end else if (hit) begin
                    score_inc_s = 1'b1;
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_NEWBALL: begin
                if (timer_done_s && btn_s) begin
                    state_d = ST_PLAY;
                end else begin
                    state_d = ST_NEWBALL;
                end
            end
            ST_OVER: begin
                if (timer_done_s) begin
                    state_d = ST_NEWGAME;
                end else begin
                    state_d = ST_OVER;
                end
            end
            default: begin
                state_d = ST_NEWGAME;
            end
        endcase

        graph_still_d = (state_d != ST_PLAY);
        text_mode_d   = text_for_state(state_d);
    end

`ifdef PONG_CTRL_HISCORE_EN
    // High score captured on the PLAY to OVER transition.
    always_comb begin
        if ((state_q == ST_PLAY) && (state_d == ST_OVER) && (score_bcd > hiscore_q)) begin
            hiscore_d = score_bcd;
        end else begin
            hiscore_d = hiscore_q;
        end
    end
`endif

    // Controller state and registered outputs.
    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            state_q        <= ST_NEWGAME;
            refresh_tick_q <= 1'b0;
            graph_still_q  <= 1'b1;
            ball_reset_q   <= 1'b0;
            balls_left_q   <= 2'(NUM_BALLS);
            text_mode_q    <= TXT_LOGO;
            timer_q        <= '0;
`ifdef PONG_CTRL_HISCORE_EN
            hiscore_q      <= 8'h00;
`endif
        end else begin
            state_q        <= state_d;
            refresh_tick_q <= refresh_tick_d;
            graph_still_q  <= graph_still_d;
            ball_reset_q   <= ball_reset_d;
            balls_left_q   <= balls_left_d;
            text_mode_q    <= text_mode_d;
            timer_q        <= timer_d;
`ifdef PONG_CTRL_HISCORE_EN
            hiscore_q      <= hiscore_d;
`endif
        end
    end

    pong_bcd_counter u_score (
        .clk   (clk_100MHz),
        .rst_n (reset),
        .clr   (score_clr_s),
        .inc   (score_inc_s),
        .bcd   (score_bcd)
    );

    assign refresh_tick = refresh_tick_q;
    assign graph_still  = graph_still_q;
    assign ball_reset   = ball_reset_q;
    assign balls_left   = balls_left_q;
    assign text_mode    = text_mode_q;
`ifdef PONG_CTRL_HISCORE_EN
    assign hiscore_bcd  = hiscore_q;
`endif

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game-flow sequencer for the pong datapath. Generates a once-per-frame refresh tick from the VGA scan position and runs the game FSM: attract/new-game, play, new-ball wait, game-over. Keeps the BCD score and the count of balls left. Drives pixel_gen's freeze and ball-reset controls and the text overlay mode. Sits beside pixel_gen, fed by vga_controller's x/y/p_tick and pixel_gen's hit/miss pulses.

Parameters:
V_TICK_LINE, 481, scan line on which the refresh tick fires (x==0)
TIMER_TICKS, 120, refresh ticks in the new-ball / game-over wait (2 s at 60 Hz)
TIMER_W, 7, timer counter width; must hold TIMER_TICKS
NUM_BALLS, 3, balls per game, 1..3

Ports:
clk_100MHz  in  1  system clock
reset  in  1  synchronous, active-low reset
p_tick  in  1  pixel enable from vga_controller
x  in  10  current pixel column
y  in  10  current pixel row
up  in  1  button, level
down  in  1  button, level
hit  in  1  1-cycle pulse, paddle hit ball
miss  in  1  1-cycle pulse, ball passed paddle
refresh_tick  out  1  1-cycle frame pulse
graph_still  out  1  1 = pixel_gen freezes ball/paddle motion
ball_reset  out  1  1-cycle pulse, re-centre ball
score_bcd  out  8  two BCD digits, [7:4] tens
balls_left  out  2  remaining balls
text_mode  out  2  0 = LOGO, 1 = PLAY, 2 = NEWBALL, 3 = OVER

Behaviour:
- All state updates on posedge clk_100MHz. reset==0 at the edge -> state NEWGAME, score_bcd=8'h00, balls_left=NUM_BALLS, timer=0, ball_reset=0, refresh_tick=0.
- refresh_tick is registered: set to 1 for exactly one clk when p_tick && x==0 && y==V_TICK_LINE, else 0. Latency is 1 clk.
- btn = up | down.
- timer:
  - loaded with TIMER_TICKS on the cycle a miss is accepted;
  - else decrements on refresh_tick when nonzero;
  - timer_done = (timer==0).
- FSM, with registered outputs per state:
  - NEWGAME: graph_still=1, text_mode=0.
    - btn -> PLAY; score<=0, balls_left<=NUM_BALLS, ball_reset pulse.
  - PLAY: graph_still=0, text_mode=1.
    - hit -> score += 1, BCD increment: units 9 -> 0 with carry, 99 -> 00 wrap.
    - miss -> ball_reset pulse and timer load.
    - If balls_left==1: balls_left<=0, go to OVER. Else balls_left -= 1, go to NEWBALL.
  - NEWBALL: graph_still=1, text_mode=2.
    - timer_done && btn -> PLAY. A btn held during the wait is honoured when the timer expires.
  - OVER: graph_still=1, text_mode=3.
    - timer_done -> NEWGAME. btn is ignored.
- hit and miss in the same cycle in PLAY: miss wins; score is not incremented.
- hit and miss outside PLAY are ignored. No score or ball change.
- ball_reset high for exactly one clk per event; never high in two consecutive cycles.
- Reset mid-wait or mid-play: aborts immediately to the reset values; timer cleared.

Optional Feature:
PONG_CTRL_HISCORE_EN
- Defined:
  - adds output hiscore_bcd[7:0], reset 8'h00;
  - on each transition PLAY -> OVER, hiscore_bcd <= score_bcd if score_bcd > hiscore_bcd;
  - BCD compare is done as an unsigned 8-bit compare, which is valid for BCD;
  - register is preserved across games and cleared only by reset.
- Undefined: port and register are absent; all other behaviour is identical.

Decomposition:
- Shared package pong_pkg:
  - state enum (NEWGAME, PLAY, NEWBALL, OVER);
  - text_mode codes;
  - default V_TICK_LINE and TIMER_TICKS constants.
- One sub-module: pong_bcd_counter. 2-digit BCD, inputs clr and inc, output bcd[7:0], wrap at 99. Reused later by the text/score renderer.

Test Plan:
- Assert reset==0 for 2 clks, then release -> graph_still=1, text_mode=0, score_bcd=00, balls_left=3, ball_reset=0.
- Sweep x/y with p_tick every 4th clk; at x=0, y=481 -> exactly one refresh_tick pulse per frame, 1 clk wide, 1 clk after the match.
- Press up in NEWGAME, then apply 12 hit pulses -> one ball_reset pulse, then PLAY with graph_still=0 and score_bcd=8'h12. A hit together with a miss adds nothing.
- Apply a miss in PLAY -> balls_left=2, NEWBALL, ball_reset pulse, timer=120. Hold down throughout: stays in NEWBALL for 120 refresh ticks, then PLAY on the expiry cycle.
- Score wrap: preset score 99 via hits, apply one hit -> 00. Three misses -> OVER with text_mode=3; up is ignored; after 120 ticks -> NEWGAME.
- With PONG_CTRL_HISCORE_EN: game 1 ends at 07, game 2 ends at 05 -> hiscore_bcd=07. Assert reset -> 00.
